// File: rtl/index_write_scheduler.sv
// Write-port arbiter for the frame index memory: round-robin between two requesters,
// plus a full-screen clear engine, with optional blanking-only write slots.
module index_write_scheduler #(
    parameter int ADDR_W       = 19,
    parameter int DATA_W       = 3,
    parameter int FRAME_PIXELS = 307200,
    parameter int BG_INDEX     = 0
) (
    input  logic              iVGA_CLK,
    input  logic              iRST_n,
    input  logic              in_blank,
    input  logic              blank_only,
    input  logic              clr_req,
    output logic              clr_busy,
    input  logic              r0_valid,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_data,
    output logic              r0_ready,
    input  logic              r1_valid,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_data,
    output logic              r1_ready,
    output logic              mem_wenable,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [15:0]       drop_count
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);
    localparam logic [DATA_W-1:0] BG_VAL    = DATA_W'(BG_INDEX);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic                last_grant_q, last_grant_d;
    logic                wen_q, wen_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [15:0]         drop_q, drop_d;

    logic                slot_ok;
    logic                can_grant;
    logic                gnt0, gnt1;
    logic                clr_step;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;

    assign slot_ok = ~blank_only | in_blank;

    // State register
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (clr_req) state_d = CLEAR;
            CLEAR:   if (slot_ok && (clr_cnt_q == LAST_ADDR)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: a clear request claims the cycle, so no grant alongside it.
    // last_grant_q=1 means r1 was served last, so r0 wins a tie.
    always_comb begin
        can_grant = (state_q == IDLE) && !clr_req && slot_ok;
        gnt0      = can_grant && r0_valid && (!r1_valid || last_grant_q);
        gnt1      = can_grant && r1_valid && (!r0_valid || !last_grant_q);
        clr_step  = (state_q == CLEAR) && slot_ok;
    end

    assign sel_addr = gnt1 ? r1_addr : r0_addr;
    assign sel_data = gnt1 ? r1_data : r0_data;

    always_comb begin
        clr_cnt_d    = clr_cnt_q;
        last_grant_d = last_grant_q;
        wen_d        = 1'b0;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        drop_d       = drop_q;
        if (state_q == IDLE && clr_req) begin
            clr_cnt_d = '0;
        end else if (clr_step) begin
            wen_d     = 1'b1;
            waddr_d   = clr_cnt_q;
            wdata_d   = BG_VAL;
            clr_cnt_d = (clr_cnt_q == LAST_ADDR) ? '0 : clr_cnt_q + ADDR_W'(1);
        end else if (gnt0 || gnt1) begin
            last_grant_d = gnt1;
            // Out-of-range writes are accepted to free the requester, then discarded
            if (sel_addr <= LAST_ADDR) begin
                wen_d   = 1'b1;
                waddr_d = sel_addr;
                wdata_d = sel_data;
            end else if (drop_q != 16'hFFFF) begin
                drop_d = drop_q + 16'd1;
            end
        end
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            clr_cnt_q    <= '0;
            last_grant_q <= 1'b1;
            wen_q        <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            drop_q       <= '0;
        end else begin
            clr_cnt_q    <= clr_cnt_d;
            last_grant_q <= last_grant_d;
            wen_q        <= wen_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            drop_q       <= drop_d;
        end
    end

    // Readies are forced low while reset is held, independent of the request inputs
    assign r0_ready    = gnt0 & iRST_n;
    assign r1_ready    = gnt1 & iRST_n;
    assign clr_busy    = (state_q == CLEAR);
    assign mem_wenable = wen_q;
    assign mem_waddr   = waddr_q;
    assign mem_wdata   = wdata_q;
    assign drop_count  = drop_q;

endmodule

// File: tb/tb_index_write_scheduler.sv
// Scoreboard bench for index_write_scheduler: stimulus queues expected grants and
// memory writes, a negedge monitor pops and compares them as the DUT produces them.
module tb_index_write_scheduler;

    localparam int AW = 19;
    localparam int DW = 3;
    localparam int FP = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_blank = 1'b0;
    logic          blank_only = 1'b0;
    logic          clr_req = 1'b0;
    logic          clr_busy;
    logic          r0_valid = 1'b0, r1_valid = 1'b0;
    logic [AW-1:0] r0_addr = '0, r1_addr = '0;
    logic [DW-1:0] r0_data = '0, r1_data = '0;
    logic          r0_ready, r1_ready;
    logic          mem_wenable;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic [15:0]   drop_count;

    index_write_scheduler #(
        .ADDR_W(AW), .DATA_W(DW), .FRAME_PIXELS(FP), .BG_INDEX(0)
    ) dut (
        .iVGA_CLK(clk), .iRST_n(rst_n), .in_blank(in_blank), .blank_only(blank_only),
        .clr_req(clr_req), .clr_busy(clr_busy),
        .r0_valid(r0_valid), .r0_addr(r0_addr), .r0_data(r0_data), .r0_ready(r0_ready),
        .r1_valid(r1_valid), .r1_addr(r1_addr), .r1_data(r1_data), .r1_ready(r1_ready),
        .mem_wenable(mem_wenable), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t exp_wr[$];
    int  exp_gnt[$];
    int  n_cmp = 0;
    int  n_err = 0;
    bit  pat_en = 1'b0;
    int  pat_cnt = 0;

    task automatic chk(input string name, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input int a, input int d);
        wr_t w;
        w.a = AW'(a);
        w.d = DW'(d);
        exp_wr.push_back(w);
    endtask

    // Blanking pattern: 3 cycles high, 3 cycles low
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (pat_en) begin
                in_blank = (pat_cnt % 6) < 3;
                pat_cnt++;
            end
        end
    end

    // Monitor
    initial begin
        bit  prev_slot = 1'b1;
        wr_t w, got_w;
        forever begin
            @(negedge clk);
            if (r0_ready && r1_ready) chk("both_ready", 1, 0);
            if (r0_ready || r1_ready) begin
                if (exp_gnt.size() == 0) chk("unexpected_grant", r1_ready, 2);
                else chk("grant_order", r1_ready ? 1 : 0, exp_gnt.pop_front());
                chk("grant_in_slot", blank_only & ~in_blank, 0);
            end
            if (mem_wenable) begin
                chk("write_after_slot", prev_slot, 1);
                got_w.a = mem_waddr;
                got_w.d = mem_wdata;
                if (exp_wr.size() == 0) chk("unexpected_write", got_w, '1);
                else begin
                    w = exp_wr.pop_front();
                    chk("write_addr_data", got_w, w);
                end
            end
            prev_slot = ~blank_only | in_blank;
        end
    end

    task automatic send(input int who, input int a, input int d, input bit drop);
        bit got = 1'b0;
        exp_gnt.push_back(who);
        if (!drop) push_wr(a, d);
        if (who == 0) begin
            r0_valid = 1'b1; r0_addr = AW'(a); r0_data = DW'(d);
        end else begin
            r1_valid = 1'b1; r1_addr = AW'(a); r1_data = DW'(d);
        end
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if ((who == 0 && r0_ready) || (who == 1 && r1_ready)) got = 1'b1;
            tick();
            if (got) break;
        end
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        if (!got) chk("send_timeout", 0, 1);
    endtask

    task automatic do_clear();
        bit done = 1'b0;
        for (int i = 0; i < FP; i++) push_wr(i, 0);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (!clr_busy) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        if (!done) chk("clear_timeout", 0, 1);
        tick();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int busy_cnt, ready_k;
        bit got;

        // Reset values
        #2;
        chk("rst_wenable", mem_wenable, 0);
        chk("rst_waddr", mem_waddr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_busy", clr_busy, 0);
        #10;
        rst_n = 1'b1;
        tick();

        // Single write, same-cycle ready, next-cycle memory write
        send(0, 13, 5, 0);
        repeat (2) tick();

        // Both requesters held: strict alternation starting with r0 after reset
        apply_reset();
        r0_valid = 1; r0_addr = 0; r0_data = 1;
        r1_valid = 1; r1_addr = 8; r1_data = 4;
        for (int i = 0; i < 3; i++) begin
            exp_gnt.push_back(0); push_wr(i, i + 1);
            exp_gnt.push_back(1); push_wr(8 + i, 4 + i);
        end
        for (int c = 0; c < 6; c++) begin
            tick();
            if (c % 2 == 0) begin
                if (c == 4) r0_valid = 0;
                else begin r0_addr = AW'(c / 2 + 1); r0_data = DW'(c / 2 + 2); end
            end else begin
                if (c == 5) r1_valid = 0;
                else begin r1_addr = AW'(8 + c / 2 + 1); r1_data = DW'(4 + c / 2 + 1); end
            end
        end
        chk("alt_valids_done", {r0_valid, r1_valid}, 0);
        repeat (2) tick();

        // Clear with r1 waiting; second clr_req mid-clear is ignored
        clr_req = 1; r1_valid = 1; r1_addr = 3; r1_data = 7;
        for (int i = 0; i < FP; i++) push_wr(i, 0);
        exp_gnt.push_back(1); push_wr(3, 7);
        busy_cnt = 0; ready_k = -1; got = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (r1_ready) begin got = 1; ready_k = k; end
            else if (clr_busy) busy_cnt++;
            tick();
            clr_req = (k == 4);
            if (got) break;
        end
        r1_valid = 0;
        clr_req = 0;
        chk("clear_r1_granted", got, 1);
        chk("clear_r1_wait", ready_k, 17);
        chk("clear_busy_cycles", busy_cnt, 16);
        chk("clear_busy_done", clr_busy, 0);
        repeat (2) tick();

        // Blanking-only writes with a request stream and a clear
        blank_only = 1; pat_cnt = 0; pat_en = 1;
        send(0, 1, 1, 0);
        send(0, 2, 2, 0);
        send(1, 3, 3, 0);
        do_clear();
        send(1, 4, 4, 0);
        repeat (4) tick();
        pat_en = 0; in_blank = 0; blank_only = 0;
        tick();

        // Out-of-range drops and saturation
        send(1, 307200, 1, 1);
        chk("drop_one", drop_count, 1);
        send(1, FP, 2, 1);
        chk("drop_boundary", drop_count, 2);
        send(1, FP - 1, 6, 0);
        chk("no_drop_last_addr", drop_count, 2);
        tick();
        for (int i = 0; i < 65540; i++) exp_gnt.push_back(1);
        r1_valid = 1; r1_addr = 20; r1_data = 1;
        repeat (65533) tick();
        chk("drop_reach_max", drop_count, 16'hFFFF);
        repeat (7) tick();
        r1_valid = 0;
        chk("drop_saturated", drop_count, 16'hFFFF);
        tick();

        // Reset in the middle of a clear at counter 7
        for (int i = 0; i < 7; i++) push_wr(i, 0);
        clr_req = 1;
        tick();
        clr_req = 0;
        repeat (7) tick();
        @(negedge clk);
        #1;
        r0_valid = 1; r0_addr = 9; r0_data = 2;
        rst_n = 0;
        #1;
        chk("mid_rst_busy", clr_busy, 0);
        chk("mid_rst_wenable", mem_wenable, 0);
        chk("mid_rst_waddr", mem_waddr, 0);
        chk("mid_rst_drop", drop_count, 0);
        chk("mid_rst_ready", {r0_ready, r1_ready}, 0);
        r0_valid = 0;
        #2;
        rst_n = 1;
        tick();
        chk("post_rst_idle", clr_busy, 0);
        send(0, 9, 2, 0);
        repeat (3) tick();

        chk("leftover_writes", exp_wr.size(), 0);
        chk("leftover_grants", exp_gnt.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
